painterengine_gpu_writer_scheduler: RTL and testbench

- Shares one painterengine_gpu_dma_writer instance between PARAM_REQUESTERS GPU clients using round-robin arbitration.
- Owns the writer's active-low resetn, which it uses as the writer's start/re-arm control.
- Routes the granted client's address, length and data stream to the writer, and returns done/error to that client as one-cycle pulses.
- Sits between the GPU render units and the AXI DMA writer.

---
 rtl/painterengine_gpu_writer_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_painterengine_gpu_writer_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/painterengine_gpu_writer_scheduler.sv
// Round-robin scheduler that shares one painterengine_gpu_dma_writer between GPU clients.
// Optional watchdog: define PAINTERENGINE_GPU_WRITER_SCHEDULER_TIMEOUT_EN.
module painterengine_gpu_writer_scheduler #(
    parameter int PARAM_REQUESTERS    = 4,
    parameter int PARAM_ADDRESS_WIDTH = 32,
    parameter int PARAM_DATA_WIDTH    = 32,
    parameter int PARAM_TIMEOUT       = 1048576
) (
    input  logic                                           i_wire_clock,
    input  logic                                           i_wire_reset,
    input  logic [PARAM_REQUESTERS-1:0]                    i_wire_req,
    input  logic [PARAM_REQUESTERS*PARAM_ADDRESS_WIDTH-1:0] i_wire_address,
    input  logic [PARAM_REQUESTERS*32-1:0]                 i_wire_length,
    input  logic [PARAM_REQUESTERS*PARAM_DATA_WIDTH-1:0]   i_wire_data,
    input  logic [PARAM_REQUESTERS-1:0]                    i_wire_data_valid,
    output logic [PARAM_REQUESTERS-1:0]                    o_wire_data_next,
    output logic [PARAM_REQUESTERS-1:0]                    o_wire_grant,
    output logic [PARAM_REQUESTERS-1:0]                    o_wire_done,
    output logic [PARAM_REQUESTERS-1:0]                    o_wire_error,
    output logic                                           o_wire_dma_resetn,
    output logic [PARAM_ADDRESS_WIDTH-1:0]                 o_wire_dma_address,
    output logic [31:0]                                    o_wire_dma_length,
    output logic [PARAM_DATA_WIDTH-1:0]                    o_wire_dma_data,
    output logic                                           o_wire_dma_data_valid,
    input  logic                                           i_wire_dma_data_next,
    input  logic                                           i_wire_dma_done,
    input  logic                                           i_wire_dma_error
);

    localparam int N     = PARAM_REQUESTERS;
    localparam int AW    = PARAM_ADDRESS_WIDTH;
    localparam int DW    = PARAM_DATA_WIDTH;
    localparam int IDX_W = $clog2(PARAM_REQUESTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   N_WIDE   = (IDX_W + 1)'(N);

    if (PARAM_REQUESTERS < 2 || PARAM_REQUESTERS > 8) begin : g_bad_requesters
        $error("PARAM_REQUESTERS must lie within 2..8");
    end
    if (PARAM_TIMEOUT < 2) begin : g_bad_timeout
        $error("PARAM_TIMEOUT must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [N-1:0]      done_q, done_d;
    logic [N-1:0]      error_q, error_d;
    logic              dma_resetn_q, dma_resetn_d;
    logic [AW-1:0]     address_q, address_d;
    logic [31:0]       length_q, length_d;

    logic              arb_found;
    logic [IDX_W-1:0]  arb_idx;
    logic [IDX_W:0]    arb_sum;
    logic [AW-1:0]     arb_address;
    logic [31:0]       arb_length;
    logic              finish;
    logic              finish_err;

`ifdef PAINTERENGINE_GPU_WRITER_SCHEDULER_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(PARAM_TIMEOUT - 1);
    logic [31:0] wdog_q, wdog_d;
    logic        wdog_expired;
`endif

    // Round-robin search: the client at rr_q has top priority, then rr_q+1, wrapping at N.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        arb_found   = 1'b0;
        arb_idx     = '0;
        arb_sum     = '0;
        arb_address = '0;
        arb_length  = '0;
        for (int i = 0; i < N; i++) begin
            arb_sum = {1'b0, rr_q} + (IDX_W + 1)'(i);
            if (arb_sum >= N_WIDE) begin
                arb_sum = arb_sum - N_WIDE;
            end
            if (!arb_found && i_wire_req[arb_sum[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_sum[IDX_W-1:0];
            end
        end
        for (int k = 0; k < N; k++) begin
            if (arb_idx == IDX_W'(k)) begin
                arb_address = i_wire_address[k*AW +: AW];
                arb_length  = i_wire_length[k*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        owner_d      = owner_q;
        grant_d      = grant_q;
        done_d       = '0;
        error_d      = '0;
        dma_resetn_d = dma_resetn_q;
        address_d    = address_q;
        length_d     = length_q;
        finish       = i_wire_dma_done || i_wire_dma_error;
        finish_err   = i_wire_dma_error;
`ifdef PAINTERENGINE_GPU_WRITER_SCHEDULER_TIMEOUT_EN
        wdog_d       = wdog_q;
        wdog_expired = (wdog_q == TIMEOUT_LAST);
        finish       = finish || wdog_expired;
        finish_err   = finish_err || (wdog_expired && !i_wire_dma_done);
`endif

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d      = ST_RUN;
                    owner_d      = arb_idx;
                    grant_d      = N'(1) << arb_idx;
                    dma_resetn_d = 1'b1;
                    address_d    = arb_address;
                    length_d     = arb_length;
`ifdef PAINTERENGINE_GPU_WRITER_SCHEDULER_TIMEOUT_EN
                    wdog_d       = '0;
`endif
                end
            end

            ST_RUN: begin
`ifdef PAINTERENGINE_GPU_WRITER_SCHEDULER_TIMEOUT_EN
                wdog_d = wdog_q + 32'd1;
`endif
                if (finish) begin
                    // Dropping resetn here re-arms (or aborts) the writer for the next owner.
                    state_d      = ST_RELEASE;
                    grant_d      = '0;
                    dma_resetn_d = 1'b0;
                    rr_d         = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                    if (finish_err) begin
                        error_d = grant_q;
                    end else begin
                        done_d = grant_q;
                    end
                end
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d      = ST_IDLE;
                grant_d      = '0;
                dma_resetn_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            state_q      <= ST_IDLE;
            rr_q         <= '0;
            owner_q      <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            error_q      <= '0;
            dma_resetn_q <= 1'b0;
            address_q    <= '0;
            length_q     <= '0;
`ifdef PAINTERENGINE_GPU_WRITER_SCHEDULER_TIMEOUT_EN
            wdog_q       <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            rr_q         <= rr_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            error_q      <= error_d;
            dma_resetn_q <= dma_resetn_d;
            address_q    <= address_d;
            length_q     <= length_d;
`ifdef PAINTERENGINE_GPU_WRITER_SCHEDULER_TIMEOUT_EN
            wdog_q       <= wdog_d;
`endif
        end
    end

    // Data path follows the registered grant, so non-owners never see data_next.
    always_comb begin
        o_wire_dma_data       = '0;
        o_wire_dma_data_valid = 1'b0;
        o_wire_data_next      = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_q[k]) begin
                o_wire_dma_data       = i_wire_data[k*DW +: DW];
                o_wire_dma_data_valid = i_wire_data_valid[k];
                o_wire_data_next[k]   = i_wire_dma_data_next;
            end
        end
    end

    assign o_wire_grant       = grant_q;
    assign o_wire_done        = done_q;
    assign o_wire_error       = error_q;
    assign o_wire_dma_resetn  = dma_resetn_q;
    assign o_wire_dma_address = address_q;
    assign o_wire_dma_length  = length_q;

endmodule

// File: tb/tb_painterengine_gpu_writer_scheduler.sv
// Directed bench for painterengine_gpu_writer_scheduler with a small DMA writer model.
// The watchdog scenario runs when PAINTERENGINE_GPU_WRITER_SCHEDULER_TIMEOUT_EN is defined.
module tb_painterengine_gpu_writer_scheduler;

    localparam int N       = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 100;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] address;
    logic [N*32-1:0] length;
    logic [N*DW-1:0] data;
    logic [N-1:0]    data_valid;
    logic [N-1:0]    data_next;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [N-1:0]    error;
    logic            dma_resetn;
    logic [AW-1:0]   dma_address;
    logic [31:0]     dma_length;
    logic [DW-1:0]   dma_data;
    logic            dma_data_valid;
    logic            dma_data_next;
    logic            dma_done;
    logic            dma_error;

    logic [31:0]     wr_cnt;
    logic            both_mode;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    painterengine_gpu_writer_scheduler #(
        .PARAM_REQUESTERS   (N),
        .PARAM_ADDRESS_WIDTH(AW),
        .PARAM_DATA_WIDTH   (DW),
        .PARAM_TIMEOUT      (TIMEOUT)
    ) dut (
        .i_wire_clock         (clk),
        .i_wire_reset         (rst),
        .i_wire_req           (req),
        .i_wire_address       (address),
        .i_wire_length        (length),
        .i_wire_data          (data),
        .i_wire_data_valid    (data_valid),
        .o_wire_data_next     (data_next),
        .o_wire_grant         (grant),
        .o_wire_done          (done),
        .o_wire_error         (error),
        .o_wire_dma_resetn    (dma_resetn),
        .o_wire_dma_address   (dma_address),
        .o_wire_dma_length    (dma_length),
        .o_wire_dma_data      (dma_data),
        .o_wire_dma_data_valid(dma_data_valid),
        .i_wire_dma_data_next (dma_data_next),
        .i_wire_dma_done      (dma_done),
        .i_wire_dma_error     (dma_error)
    );

    // Writer model: accepts one word per cycle while armed, done once length words are taken,
    // error at once for zero length; both_mode raises done and error together.
    always_ff @(posedge clk) begin
        if (!dma_resetn) begin
            wr_cnt <= '0;
        end else if (dma_data_valid && dma_data_next) begin
            wr_cnt <= wr_cnt + 32'd1;
        end
    end

    assign dma_data_next = dma_resetn && (wr_cnt < dma_length);
    assign dma_done      = dma_resetn && (dma_length != 0) && (wr_cnt == dma_length);
    assign dma_error     = dma_resetn && ((dma_length == 0) ||
                           (both_mode && (dma_length != 0) && (wr_cnt == dma_length)));

    task automatic set_client(input int k, input logic [AW-1:0] a, input logic [31:0] l);
        address[k*AW +: AW] = a;
        length[k*32 +: 32]  = l;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst        = 1'b1;
        req        = '0;
        data_valid = '0;
        both_mode  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(output bit ok);
        int n;
        n = 0;
        while (grant == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (grant != '0);
    endtask

    task automatic wait_finish(output bit ok);
        int n;
        n = 0;
        while ((done | error) == '0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        ok = ((done | error) != '0);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req        = '0;
        data_valid = '0;
        both_mode  = 1'b0;
        address    = '0;
        length     = '0;
        data       = '0;
        repeat (2) @(negedge clk);
        tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b, expected 0000", grant); end
        tests_run++; if (done !== 4'b0000) begin tests_failed++; $display("FAIL reset_done: got %b, expected 0000", done); end
        tests_run++; if (error !== 4'b0000) begin tests_failed++; $display("FAIL reset_error: got %b, expected 0000", error); end
        tests_run++; if (dma_resetn !== 1'b0) begin tests_failed++; $display("FAIL reset_dma_resetn: got %b, expected 0", dma_resetn); end
        tests_run++; if (dma_address !== 32'h0) begin tests_failed++; $display("FAIL reset_dma_address: got %h, expected 0", dma_address); end
        tests_run++; if (dma_length !== 32'h0) begin tests_failed++; $display("FAIL reset_dma_length: got %h, expected 0", dma_length); end
        tests_run++; if (data_next !== 4'b0000) begin tests_failed++; $display("FAIL reset_data_next: got %b, expected 0000", data_next); end
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if ({grant, dma_resetn} !== 5'b0) begin tests_failed++; $display("FAIL idle_no_req: got grant=%b resetn=%b, expected 0/0", grant, dma_resetn); end
    endtask

    task automatic test_single();
        bit ok;
        apply_reset();
        set_client(0, 32'h1000, 32'd16);
        data[0 +: DW] = 32'hC0DE_0000;
        data_valid    = 4'b0001;
        req           = 4'b0001;
        @(negedge clk);
        tests_run++; if (dma_resetn !== 1'b1) begin tests_failed++; $display("FAIL single_resetn: got %b, expected 1", dma_resetn); end
        tests_run++; if (grant !== 4'b0001) begin tests_failed++; $display("FAIL single_grant: got %b, expected 0001", grant); end
        tests_run++; if (dma_address !== 32'h1000) begin tests_failed++; $display("FAIL single_address: got %h, expected 00001000", dma_address); end
        tests_run++; if (dma_length !== 32'd16) begin tests_failed++; $display("FAIL single_length: got %0d, expected 16", dma_length); end
        req = '0;
        wait_finish(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL single_finish: got no pulse, expected done"); end
        tests_run++; if (done !== 4'b0001) begin tests_failed++; $display("FAIL single_done: got %b, expected 0001", done); end
        tests_run++; if (error !== 4'b0000) begin tests_failed++; $display("FAIL single_error: got %b, expected 0000", error); end
        tests_run++; if ({grant, dma_resetn} !== 5'b0) begin tests_failed++; $display("FAIL single_release: got grant=%b resetn=%b, expected 0/0", grant, dma_resetn); end
        tests_run++; if (wr_cnt !== 32'd16) begin tests_failed++; $display("FAIL single_words: got %0d, expected 16", wr_cnt); end
        @(negedge clk);
        tests_run++; if (done !== 4'b0000) begin tests_failed++; $display("FAIL single_done_pulse: got %b, expected 0000", done); end
    endtask

    task automatic test_back_to_back();
        int low;
        int n;
        logic [N-1:0] exp_grant;
        apply_reset();
        for (int k = 0; k < N; k++) begin
            set_client(k, 32'(32'h100 * (k + 1)), 32'd2);
        end
        data_valid = 4'b1111;
        req        = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            low = 0;
            n   = 0;
            while (grant == '0 && n < 50) begin
                if (g > 0) begin
                    tests_run++; if (dma_resetn !== 1'b0) begin tests_failed++; $display("FAIL rr_gap_resetn: got %b, expected 0", dma_resetn); end
                end
                low++;
                n++;
                @(negedge clk);
            end
            exp_grant = N'(1) << (g % N);
            tests_run++; if (grant !== exp_grant) begin tests_failed++; $display("FAIL rr_grant[%0d]: got %b, expected %b", g, grant, exp_grant); end
            if (g > 0) begin
                tests_run++; if (low != 2) begin tests_failed++; $display("FAIL rr_gap[%0d]: got %0d cycles, expected 2", g, low); end
            end
            tests_run++; if (dma_address !== 32'(32'h100 * ((g % N) + 1))) begin tests_failed++; $display("FAIL rr_address[%0d]: got %h", g, dma_address); end
            if (g == 4) req = '0;
            n = 0;
            while (grant != '0 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_data_isolation();
        bit ok;
        int n;
        logic [DW-1:0] exp_data;
        apply_reset();
        set_client(2, 32'h2000, 32'd8);
        data[0*DW +: DW] = 32'hAAAA_0000;
        data[3*DW +: DW] = 32'h3333_0000;
        exp_data         = 32'h2222_0000;
        data[2*DW +: DW] = exp_data;
        data_valid       = 4'b1101;
        req              = 4'b0100;
        wait_grant(ok);
        tests_run++; if (grant !== 4'b0100) begin tests_failed++; $display("FAIL iso_grant: got %b, expected 0100", grant); end
        req = '0;
        n   = 0;
        while (grant != '0 && n < 50) begin
            tests_run++; if (data_next[0] !== 1'b0 || data_next[3] !== 1'b0 || data_next[1] !== 1'b0) begin tests_failed++; $display("FAIL iso_data_next: got %b, only bit 2 may be set", data_next); end
            tests_run++; if (dma_data !== exp_data) begin tests_failed++; $display("FAIL iso_dma_data: got %h, expected %h", dma_data, exp_data); end
            tests_run++; if (data_next[2] !== dma_data_next) begin tests_failed++; $display("FAIL iso_owner_next: got %b, expected %b", data_next[2], dma_data_next); end
            exp_data         = exp_data + 32'd1;
            data[2*DW +: DW] = exp_data;
            n++;
            @(negedge clk);
        end
        tests_run++; if (done !== 4'b0100) begin tests_failed++; $display("FAIL iso_done: got %b, expected 0100", done); end
        tests_run++; if (data_next !== 4'b0000) begin tests_failed++; $display("FAIL iso_release_next: got %b, expected 0000", data_next); end
        data_valid = '0;
    endtask

    task automatic test_done_and_error();
        bit ok;
        apply_reset();
        both_mode = 1'b1;
        set_client(1, 32'h3000, 32'd4);
        data_valid = 4'b0010;
        req        = 4'b0010;
        wait_grant(ok);
        tests_run++; if (grant !== 4'b0010) begin tests_failed++; $display("FAIL both_grant: got %b, expected 0010", grant); end
        req = '0;
        wait_finish(ok);
        tests_run++; if (error !== 4'b0010) begin tests_failed++; $display("FAIL both_error: got %b, expected 0010", error); end
        tests_run++; if (done !== 4'b0000) begin tests_failed++; $display("FAIL both_done: got %b, expected 0000", done); end
        @(negedge clk);
        tests_run++; if ({done, error} !== 8'b0) begin tests_failed++; $display("FAIL both_pulse: got done=%b error=%b, expected 0/0", done, error); end
        both_mode = 1'b0;
    endtask

    task automatic test_zero_length();
        bit ok;
        set_client(3, 32'h4002, 32'd0);
        data_valid = 4'b1000;
        req        = 4'b1000;
        wait_grant(ok);
        tests_run++; if (grant !== 4'b1000) begin tests_failed++; $display("FAIL zero_grant: got %b, expected 1000", grant); end
        req = '0;
        wait_finish(ok);
        tests_run++; if (error !== 4'b1000 || done !== 4'b0000) begin tests_failed++; $display("FAIL zero_error: got error=%b done=%b, expected 1000/0000", error, done); end
        data_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_transfer();
        bit ok;
        int n;
        set_client(0, 32'h5000, 32'd16);
        data_valid = 4'b0001;
        req        = 4'b0001;
        wait_grant(ok);
        tests_run++; if (grant !== 4'b0001) begin tests_failed++; $display("FAIL mid_grant: got %b, expected 0001 after rr wrap", grant); end
        n = 0;
        while (wr_cnt != 32'd5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++; if (wr_cnt !== 32'd5) begin tests_failed++; $display("FAIL mid_words: got %0d, expected 5", wr_cnt); end
        req = '0;
        #1 rst = 1'b1;
        #1;
        tests_run++; if (dma_resetn !== 1'b0) begin tests_failed++; $display("FAIL mid_async_resetn: got %b, expected 0", dma_resetn); end
        tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL mid_async_grant: got %b, expected 0000", grant); end
        tests_run++; if (data_next !== 4'b0000) begin tests_failed++; $display("FAIL mid_async_next: got %b, expected 0000", data_next); end
        repeat (3) begin
            @(negedge clk);
            tests_run++; if ({done, error} !== 8'b0) begin tests_failed++; $display("FAIL mid_no_pulse: got done=%b error=%b, expected 0/0", done, error); end
        end
        rst = 1'b0;
        set_client(0, 32'h5100, 32'd4);
        req = 4'b0001;
        wait_grant(ok);
        tests_run++; if (grant !== 4'b0001 || dma_address !== 32'h5100) begin tests_failed++; $display("FAIL mid_regrant: got grant=%b addr=%h, expected 0001/00005100", grant, dma_address); end
        req = '0;
        wait_finish(ok);
        tests_run++; if (done !== 4'b0001 || error !== 4'b0000) begin tests_failed++; $display("FAIL mid_done: got done=%b error=%b, expected 0001/0000", done, error); end
        data_valid = '0;
        repeat (2) @(negedge clk);
    endtask

`ifdef PAINTERENGINE_GPU_WRITER_SCHEDULER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int cyc;
        apply_reset();
        set_client(0, 32'h6000, 32'd16);
        set_client(1, 32'h6100, 32'd2);
        data_valid = 4'b0000;
        req        = 4'b0001;
        wait_grant(ok);
        tests_run++; if (grant !== 4'b0001) begin tests_failed++; $display("FAIL wdog_grant: got %b, expected 0001", grant); end
        req = '0;
        cyc = 0;
        while ((done | error) == '0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++; if (cyc != TIMEOUT) begin tests_failed++; $display("FAIL wdog_latency: got %0d cycles, expected %0d", cyc, TIMEOUT); end
        tests_run++; if (error !== 4'b0001 || done !== 4'b0000) begin tests_failed++; $display("FAIL wdog_error: got error=%b done=%b, expected 0001/0000", error, done); end
        tests_run++; if (dma_resetn !== 1'b0) begin tests_failed++; $display("FAIL wdog_abort: got %b, expected 0", dma_resetn); end
        req        = 4'b0011;
        data_valid = 4'b0010;
        wait_grant(ok);
        tests_run++; if (grant !== 4'b0010) begin tests_failed++; $display("FAIL wdog_rr: got %b, expected 0010", grant); end
        req = '0;
        wait_finish(ok);
        tests_run++; if (done !== 4'b0010) begin tests_failed++; $display("FAIL wdog_next_done: got %b, expected 0010", done); end
        data_valid = '0;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_data_isolation();
        test_done_and_error();
        test_zero_length();
        test_reset_mid_transfer();
`ifdef PAINTERENGINE_GPU_WRITER_SCHEDULER_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation still running at %0t, expected completion", $time);
        $fatal(1, "time limit");
    end

endmodule
